// File: rtl/operand_demux_pkg.sv
// Shared definitions for the operand demux: default widths, slot encodings,
// pair-state encodings and the slot-selection helper.
package operand_demux_pkg;

   // Default widths for the operand bus and the drop counter
   localparam int DATA_W_DEF = 8;
   localparam int CNT_W_DEF  = 8;

   // Slot encodings used for the write target
   localparam logic SLOT_1 = 1'b0;
   localparam logic SLOT_2 = 1'b1;

   // Pair state as seen on Dbg_State = {B_Loaded, A_Loaded}
   localparam logic [1:0] ST_EMPTY  = 2'b00;
   localparam logic [1:0] ST_HALF_A = 2'b01;
   localparam logic [1:0] ST_HALF_B = 2'b10;
   localparam logic [1:0] ST_FULL   = 2'b11;

   // Slot that an accepted transfer lands in. Auto mode fills slot 1 first,
   // then slot 2; manual mode follows Sel directly.
   function automatic logic pick_slot(input logic sel_mode,
                                      input logic sel,
                                      input logic a_loaded);
      logic slot;
      if (sel_mode) begin
         slot = sel;
      end else begin
         slot = a_loaded ? SLOT_2 : SLOT_1;
      end
      return slot;
   endfunction

endpackage

// File: rtl/operand_demux_sat_counter.sv
// Saturating up-counter with synchronous clear. Holds at all-ones instead of
// wrapping; Clr takes priority over Inc.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         Clk,
   input  logic         Rst_n,
   input  logic         Clr,
   input  logic         Inc,
   output logic [W-1:0] Count
);

   logic [W-1:0] r_count;
   logic         w_at_max;

   assign w_at_max = (r_count == {W{1'b1}});
   assign Count    = r_count;

   // Count increments, clamped at the maximum value; clear wins over increment
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_count <= '0;
      end else if (Clr) begin
         r_count <= '0;
      end else if (Inc && !w_at_max) begin
         r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/operand_demux.sv
// Operand demux: steers one input stream into two held operand slots and
// presents the completed pair to a consumer.
//
// Handshakes:
//   Input  : a transfer happens on a rising edge where In_Valid & In_Ready.
//            In_Ready depends only on the slot flags, never on In_Valid.
//   Output : Pair_Valid stays high while both slots are loaded; a Pair_Ack
//            seen while Pair_Valid is high releases the pair at that edge.
//            An input presented in that same cycle is refused and counted
//            as a drop, so the source must present it again.
module operand_demux
   import operand_demux_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic [DATA_W-1:0] In_Data,
   input  logic              In_Valid,
   output logic              In_Ready,
   input  logic              Sel_Mode,
   input  logic              Sel,
   input  logic              Clear,
   output logic [DATA_W-1:0] Data1,
   output logic [DATA_W-1:0] Data2,
   output logic              Pair_Valid,
   input  logic              Pair_Ack,
   output logic [CNT_W-1:0]  Drop_Count,
   output logic [1:0]        Dbg_State
);

   logic              r_a_loaded;
   logic              r_b_loaded;
   logic [DATA_W-1:0] r_data1;
   logic [DATA_W-1:0] r_data2;

   logic w_full;
   logic w_accept;
   logic w_target;
   logic w_release;
   logic w_drop;

   // Ready, valid and slot selection derived from the flags
   assign w_full    = r_a_loaded & r_b_loaded;
   assign w_accept  = In_Valid & ~w_full;
   assign w_target  = pick_slot(Sel_Mode, Sel, r_a_loaded);
   assign w_release = Pair_Ack & w_full;
   assign w_drop    = In_Valid & w_full;

   assign In_Ready   = ~w_full;
   assign Pair_Valid = w_full;
   assign Data1      = r_data1;
   assign Data2      = r_data2;
   assign Dbg_State  = {r_b_loaded, r_a_loaded};

   // Slot flags: clear beats release, release beats load
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_a_loaded <= 1'b0;
         r_b_loaded <= 1'b0;
      end else if (Clear) begin
         r_a_loaded <= 1'b0;
         r_b_loaded <= 1'b0;
      end else if (w_release) begin
         r_a_loaded <= 1'b0;
         r_b_loaded <= 1'b0;
      end else if (w_accept) begin
         if (w_target == SLOT_1) begin
            r_a_loaded <= 1'b1;
         end else begin
            r_b_loaded <= 1'b1;
         end
      end
   end

   // Operand registers: written on accept, held across a release
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_data1 <= '0;
         r_data2 <= '0;
      end else if (Clear) begin
         r_data1 <= '0;
         r_data2 <= '0;
      end else if (w_accept) begin
         if (w_target == SLOT_1) begin
            r_data1 <= In_Data;
         end else begin
            r_data2 <= In_Data;
         end
      end
   end

   // Drops are transfers offered while the pair is full; Clear zeroes the
   // count and masks that cycle's drop
   sat_counter #(
      .W (CNT_W)
   ) u_drop_cnt (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .Clr   (Clear),
      .Inc   (w_drop),
      .Count (Drop_Count)
   );

endmodule

// File: tb/tb_operand_demux.sv
// Bench for operand_demux: directed scenarios plus random auto-mode pairs.
// Completed pairs are predicted into a queue when the second operand is
// driven and popped when Pair_Valid rises.
module tb_operand_demux;

   logic       clk;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       sel_mode;
   logic       sel;
   logic       clear;
   logic [7:0] data1;
   logic [7:0] data2;
   logic       pair_valid;
   logic       pair_ack;
   logic [7:0] drop_count;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] exp_q[$];
   logic        pv_prev;

   operand_demux #(
      .DATA_W (8),
      .CNT_W  (8)
   ) dut (
      .Clk        (clk),
      .Rst_n      (rst_n),
      .In_Data    (in_data),
      .In_Valid   (in_valid),
      .In_Ready   (in_ready),
      .Sel_Mode   (sel_mode),
      .Sel        (sel),
      .Clear      (clear),
      .Data1      (data1),
      .Data2      (data2),
      .Pair_Valid (pair_valid),
      .Pair_Ack   (pair_ack),
      .Drop_Count (drop_count),
      .Dbg_State  (dbg_state)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Driver: one transfer offered for one cycle, outputs sampled #1 after the edge
   task automatic send(input logic [7:0] d, input logic mode, input logic s);
      @(negedge clk);
      in_data  = d;
      in_valid = 1'b1;
      sel_mode = mode;
      sel      = s;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic pulse_ack();
      @(negedge clk);
      pair_ack = 1'b1;
      @(posedge clk);
      #1;
      pair_ack = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   task automatic wait_pair(input int budget);
      int n;
      n = 0;
      while (!pair_valid && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!pair_valid) check("pair_timeout", 32'd0, 32'd1);
   endtask

   // Scoreboard: each rising Pair_Valid must match the oldest predicted pair
   always @(negedge clk) begin
      if (pair_valid && !pv_prev) begin
         if (exp_q.size() == 0) begin
            check("pair_unexpected", 32'd1, 32'd0);
         end else begin
            check("pair", {16'd0, data1, data2}, {16'd0, exp_q.pop_front()});
         end
      end
      pv_prev <= pair_valid;
   end

   initial begin
      logic [7:0] a;
      logic [7:0] b;
      rst_n = 1'b0; in_data = '0; in_valid = 1'b0; sel_mode = 1'b0;
      sel = 1'b0; clear = 1'b0; pair_ack = 1'b0; pv_prev = 1'b0;

      // Reset values
      #1;
      check("rst_ready", {31'd0, in_ready}, 32'd1);
      check("rst_pv", {31'd0, pair_valid}, 32'd0);
      check("rst_data", {16'd0, data1, data2}, 32'h0);
      check("rst_drop", {24'd0, drop_count}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // 1. Auto fill
      send(8'h12, 1'b0, 1'b0);
      check("t1_d1", {24'd0, data1}, 32'h12);
      check("t1_pv_half", {31'd0, pair_valid}, 32'd0);
      check("t1_state_half", {30'd0, dbg_state}, 32'd1);
      exp_q.push_back(16'h1234);
      send(8'h34, 1'b0, 1'b0);
      check("t1_pv", {31'd0, pair_valid}, 32'd1);
      check("t1_d2", {24'd0, data2}, 32'h34);
      check("t1_ready_full", {31'd0, in_ready}, 32'd0);

      // 2. Backpressure with saturation
      @(negedge clk);
      in_data  = 8'hEE;
      in_valid = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         @(posedge clk);
         #1;
         if (i == 200) check("t2_drop200", {24'd0, drop_count}, 32'd200);
         if (i == 255) check("t2_drop255", {24'd0, drop_count}, 32'hFF);
      end
      check("t2_drop_sat", {24'd0, drop_count}, 32'hFF);
      check("t2_hold", {16'd0, data1, data2}, 32'h1234);
      in_valid = 1'b0;
      pulse_clear();
      check("t2_clr_drop", {24'd0, drop_count}, 32'd0);
      check("t2_clr_data", {16'd0, data1, data2}, 32'h0);
      check("t2_clr_pv", {31'd0, pair_valid}, 32'd0);

      // 3. Ack and refill
      send(8'h12, 1'b0, 1'b0);
      exp_q.push_back(16'h1234);
      send(8'h34, 1'b0, 1'b0);
      pulse_ack();
      check("t3_pv", {31'd0, pair_valid}, 32'd0);
      check("t3_ready", {31'd0, in_ready}, 32'd1);
      check("t3_retain", {16'd0, data1, data2}, 32'h1234);
      send(8'h56, 1'b0, 1'b0);
      check("t3_d1", {24'd0, data1}, 32'h56);
      check("t3_pv_half", {31'd0, pair_valid}, 32'd0);
      pulse_ack();
      check("t3_ack_ignored", {30'd0, dbg_state}, 32'd1);
      pulse_clear();

      // 4. Manual mode, overwrite of a loaded slot
      send(8'hAA, 1'b1, 1'b1);
      send(8'hBB, 1'b1, 1'b1);
      check("t4_d2", {24'd0, data2}, 32'hBB);
      check("t4_pv_half", {31'd0, pair_valid}, 32'd0);
      check("t4_state", {30'd0, dbg_state}, 32'd2);
      exp_q.push_back(16'hCCBB);
      send(8'hCC, 1'b1, 1'b0);
      check("t4_d1", {24'd0, data1}, 32'hCC);
      check("t4_pv", {31'd0, pair_valid}, 32'd1);

      // 5. Ack with a competing input, then Clear with an input
      @(negedge clk);
      pair_ack = 1'b1; in_valid = 1'b1; in_data = 8'h77; sel_mode = 1'b0;
      @(posedge clk);
      #1;
      pair_ack = 1'b0; in_valid = 1'b0;
      check("t5_pv", {31'd0, pair_valid}, 32'd0);
      check("t5_data", {16'd0, data1, data2}, 32'hCCBB);
      check("t5_drop", {24'd0, drop_count}, 32'd1);
      check("t5_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      clear = 1'b1; in_valid = 1'b1; in_data = 8'h55;
      @(posedge clk);
      #1;
      clear = 1'b0; in_valid = 1'b0;
      check("t5_clr_state", {30'd0, dbg_state}, 32'd0);
      check("t5_clr_data", {16'd0, data1, data2}, 32'h0);
      check("t5_clr_drop", {24'd0, drop_count}, 32'd0);

      // Random auto-mode pairs
      for (int k = 0; k < 6; k++) begin
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         send(a, 1'b0, 1'($urandom_range(0, 1)));
         exp_q.push_back({a, b});
         send(b, 1'b0, 1'($urandom_range(0, 1)));
         wait_pair(8);
         pulse_ack();
         check("rnd_release", {31'd0, pair_valid}, 32'd0);
      end

      // 6. Async reset mid-pair
      send(8'h99, 1'b0, 1'b0);
      check("t6_d1", {24'd0, data1}, 32'h99);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_d1_rst", {24'd0, data1}, 32'h0);
      check("t6_state_rst", {30'd0, dbg_state}, 32'd0);
      check("t6_ready_rst", {31'd0, in_ready}, 32'd1);
      check("t6_pv_rst", {31'd0, pair_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      check("queue_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
